// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if: request/acknowledge handshake between the capture controller and the ADC front end.
interface adc_capture_ctrl_if;
  logic        req;
  logic        ack;
  logic [23:0] data;
  modport master(output req, input ack, data);
  modport slave(input req, output ack, data);
endinterface

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: once-per-line ADC capture with timeout, 256-entry ring history, running totals and frame averages.
module adc_capture_ctrl #(
  parameter int LINE_HC = 532,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic                 scandouble,
  input  logic [9:0]           hc,
  input  logic [9:0]           vc,
  adc_capture_ctrl_if.master   adc,
  output logic [11:0]          cur_l,
  output logic [11:0]          cur_r,
  output logic [11:0]          prev_l,
  output logic [11:0]          prev_r,
  output logic [11:0]          avg_l,
  output logic [11:0]          avg_r,
  output logic                 sample_valid,
  output logic [7:0]           missed_cnt
);
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, UPDATE} state_t;
  state_t      state;
  logic [23:0] ring [256];
  logic [7:0]  ptr, tcnt;
  logic [11:0] old_l, old_r, new_l, new_r;
  logic [19:0] total_l, total_r, nt_l, nt_r;
  logic        hit, hit_seen, trig, drop, tout, frame_end;
  logic [8:0]  msum;
  always_comb begin
    hit  = ce_pix && hc == 10'(LINE_HC);
    trig = hit && !hit_seen;
    drop = trig && (state == WAIT || state == UPDATE);
    tout = state == WAIT && !adc.ack && tcnt == 8'(TIMEOUT - 1);
    msum = {1'b0, missed_cnt} + 9'(drop) + 9'(tout);
    // Totals never exceed 256*4095, so 20-bit modular arithmetic matches the wide result.
    nt_l = total_l - 20'(old_l) + 20'(new_l);
    nt_r = total_r - 20'(old_r) + 20'(new_r);
  end
  always_ff @(posedge clk)
    if (state == CLEAR || state == UPDATE)
      ring[ptr] <= state == UPDATE ? {new_r, new_l} : 24'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CLEAR;
      adc.req      <= 1'b0;
      ptr          <= '0;
      tcnt         <= '0;
      old_l        <= '0;
      old_r        <= '0;
      new_l        <= '0;
      new_r        <= '0;
      total_l      <= '0;
      total_r      <= '0;
      cur_l        <= '0;
      cur_r        <= '0;
      prev_l       <= '0;
      prev_r       <= '0;
      avg_l        <= '0;
      avg_r        <= '0;
      sample_valid <= 1'b0;
      missed_cnt   <= '0;
      hit_seen     <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      hit_seen     <= hc == 10'(LINE_HC) && (hit_seen || hit);
      sample_valid <= 1'b0;
      missed_cnt   <= msum[8] ? 8'hff : msum[7:0];
      case (state)
        CLEAR: begin
          ptr <= ptr + 8'd1;
          if (ptr == 8'hff) state <= IDLE;
        end
        IDLE: if (trig) begin
          adc.req        <= 1'b1;
          {old_r, old_l} <= ring[ptr];
          tcnt           <= '0;
          frame_end      <= vc == (scandouble ? 10'd524 : 10'd262);
          state          <= WAIT;
        end
        WAIT: if (adc.ack) begin
          {new_r, new_l} <= adc.data;
          adc.req        <= 1'b0;
          state          <= UPDATE;
        end else if (tout) begin
          new_l   <= cur_l;
          new_r   <= cur_r;
          adc.req <= 1'b0;
          state   <= UPDATE;
        end else tcnt <= tcnt + 8'd1;
        UPDATE: begin
          total_l      <= nt_l;
          total_r      <= nt_r;
          prev_l       <= cur_l;
          prev_r       <= cur_r;
          cur_l        <= new_l;
          cur_r        <= new_r;
          ptr          <= ptr + 8'd1;
          sample_valid <= 1'b1;
          if (frame_end) begin
            avg_l <= nt_l[19:8];
            avg_r <= nt_r[19:8];
          end
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed captures with a scoreboard queue checked by a sample_valid monitor.
module tb_adc_capture_ctrl;
  localparam int LINE_HC = 532;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0, rst_n = 1'b0, ce_pix = 1'b0, scandouble = 1'b1;
  logic [9:0] hc = '0, vc = '0;
  logic [11:0] cur_l, cur_r, prev_l, prev_r, avg_l, avg_r;
  logic sample_valid;
  logic [7:0] missed_cnt;
  int errors = 0, checks = 0;
  typedef struct {
    logic [11:0] cl, cr, pl, pr;
    int          missed;
    bit          fe;
    logic [11:0] al, ar;
  } exp_t;
  exp_t q[$];
  logic [11:0] m_cur_l = '0, m_cur_r = '0;
  int m_missed = 0;
  adc_capture_ctrl_if ifc();
  adc_capture_ctrl #(.LINE_HC(LINE_HC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n), .ce_pix(ce_pix), .scandouble(scandouble), .hc(hc), .vc(vc),
    .adc(ifc), .cur_l(cur_l), .cur_r(cur_r), .prev_l(prev_l), .prev_r(prev_r),
    .avg_l(avg_l), .avg_r(avg_r), .sample_valid(sample_valid), .missed_cnt(missed_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (sample_valid) begin
    if (q.size() == 0) chk("unexpected_sample_valid", 1, 0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("cur_l", cur_l, e.cl);
      chk("cur_r", cur_r, e.cr);
      chk("prev_l", prev_l, e.pl);
      chk("prev_r", prev_r, e.pr);
      chk("missed_cnt", missed_cnt, e.missed);
      if (e.fe) begin
        chk("avg_l", avg_l, e.al);
        chk("avg_r", avg_r, e.ar);
      end
    end
  end
  // Called at a negedge with the DUT idle; dly<0 means the ADC never acknowledges.
  task automatic capture(input logic [23:0] d, input int dly, input int hold, input int busy,
                         input bit fe, input bit sd, input logic [11:0] al, input logic [11:0] ar);
    int n = 0;
    logic [11:0] nl, nr;
    nl = dly < 0 ? m_cur_l : d[11:0];
    nr = dly < 0 ? m_cur_r : d[23:12];
    m_missed = m_missed + (dly < 0 ? 1 : 0) + (busy > 0 ? 1 : 0);
    if (m_missed > 255) m_missed = 255;
    q.push_back('{nl, nr, m_cur_l, m_cur_r, m_missed, fe, al, ar});
    m_cur_l = nl;
    m_cur_r = nr;
    scandouble = sd;
    vc = fe ? (sd ? 10'd524 : 10'd262) : 10'd100;
    hc = 10'(LINE_HC);
    ce_pix = 1'b1;
    @(negedge clk);
    while (ifc.req && n < 300) begin
      ce_pix = (n + 1 < hold) || (busy > 0 && n == busy);
      hc = ce_pix ? 10'(LINE_HC) : 10'd0;
      if (n == dly) begin
        ifc.ack = 1'b1;
        ifc.data = d;
      end
      n++;
      @(negedge clk);
    end
    chk("req_high_cycles", n, dly < 0 ? TIMEOUT : dly + 1);
    ifc.ack = 1'b0;
    ce_pix = 1'b0;
    hc = '0;
    @(negedge clk);
  endtask
  initial begin
    ifc.ack = 1'b0;
    ifc.data = '0;
    repeat (3) @(negedge clk);
    chk("reset_req", ifc.req, 0);
    chk("reset_cur_l", cur_l, 0);
    chk("reset_prev_r", prev_r, 0);
    chk("reset_avg_l", avg_l, 0);
    chk("reset_missed", missed_cnt, 0);
    chk("reset_valid", sample_valid, 0);
    rst_n = 1'b1;
    repeat (255) @(negedge clk);
    hc = 10'(LINE_HC);
    ce_pix = 1'b1;
    @(negedge clk);
    hc = '0;
    ce_pix = 1'b0;
    chk("clear_trigger_ignored", ifc.req, 0);
    chk("clear_trigger_not_counted", missed_cnt, 0);
    repeat (3) @(negedge clk);
    hc = 10'(LINE_HC);
    ce_pix = 1'b1;
    @(negedge clk);
    hc = '0;
    ce_pix = 1'b0;
    chk("idle_trigger_req", ifc.req, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_req", ifc.req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (256) @(negedge clk);
    capture(24'h123456, 3, 1, 0, 0, 1, 0, 0);
    capture(24'h000000, -1, 1, 0, 0, 1, 0, 0);
    capture(24'hABCDEF, 2, 3, 0, 0, 1, 0, 0);
    chk("held_ce_pix_single_trigger", missed_cnt, 1);
    capture(24'h000111, 5, 1, 2, 0, 1, 0, 0);
    for (int i = 0; i < 256; i++) capture(24'hFFF800, 1, 1, 0, 0, 1, 0, 0);
    capture(24'hFFF800, 0, 1, 0, 1, 1, 12'h800, 12'hFFF);
    for (int i = 0; i < 256; i++) capture(24'h000000, 4, 1, 0, 0, 0, 0, 0);
    capture(24'h000000, 1, 1, 0, 1, 0, 12'h000, 12'h000);
    for (int i = 0; i < 300; i++) capture(24'h0, -1, 1, 0, 0, 1, 0, 0);
    chk("missed_saturated", missed_cnt, 255);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
